// File: rtl/lc3_execute.sv
// lc3_execute: Execute stage of the LC-3 pipeline.
// Takes the decoded instruction and register operands, resolves operand
// forwarding from the execute and memory stages, computes the ALU result and
// the effective address, and registers everything for the next stage.
// The source/destination register fields are decoded combinationally so the
// register file and hazard logic can use them in the same cycle.
module lc3_execute #(
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable_execute,
    input  logic [15:0] IR,
    input  logic [15:0] npc_in,
    input  logic [5:0]  E_control,
    input  logic [1:0]  W_control_in,
    input  logic        Mem_control_in,
    input  logic [15:0] VSR1,
    input  logic [15:0] VSR2,
    input  logic        bypass_alu_1,
    input  logic        bypass_alu_2,
    input  logic        bypass_mem_1,
    input  logic        bypass_mem_2,
    input  logic [15:0] Mem_Bypass_Val,
    output logic [15:0] aluout,
    output logic [15:0] pcout,
    output logic [1:0]  W_control_out,
    output logic        Mem_control_out,
    output logic [15:0] M_data,
    output logic [15:0] IR_Exec,
    output logic [2:0]  NZP,
    output logic [2:0]  dr,
    output logic [2:0]  sr1,
    output logic [2:0]  sr2
);

    // Opcodes that matter to this stage
    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;

    // ALU function select encodings
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_AND  = 2'b01;
    localparam logic [1:0] ALU_NOT  = 2'b10;
    localparam logic [1:0] ALU_PASS = 2'b11;

    // Registered state behind the outputs
    logic [15:0] aluout_r;
    logic [15:0] pcout_r;
    logic [1:0]  w_control_r;
    logic        mem_control_r;
    logic [15:0] m_data_r;
    logic [15:0] ir_exec_r;
    logic [2:0]  nzp_r;

    // Decoded control fields
    logic [3:0]  opcode_s;
    logic [1:0]  alu_control_s;
    logic [1:0]  pcselect1_s;
    logic        pcselect2_s;
    logic        op2select_s;

    // Datapath intermediates
    logic [15:0] op_a_s;
    logic [15:0] op_b_s;
    logic [15:0] imm5_s;
    logic [15:0] op2_s;
    logic [15:0] alu_result_s;
    logic [15:0] offset_s;
    logic [15:0] base_s;
    logic [15:0] addr_s;
    logic        is_alu_op_s;
    logic [2:0]  nzp_next_s;
    logic [2:0]  sr2_s;

    assign opcode_s      = IR[15:12];
    assign alu_control_s = E_control[5:4];
    assign pcselect1_s   = E_control[3:2];
    assign pcselect2_s   = E_control[1];
    assign op2select_s   = E_control[0];

    // Register-field decode; stores read their data register through sr2
    always_comb begin
        sr2_s = IR[2:0];
        case (opcode_s)
            OP_ST, OP_STR, OP_STI: sr2_s = IR[11:9];
            default:               sr2_s = IR[2:0];
        endcase
    end

    assign dr  = IR[11:9];
    assign sr1 = IR[8:6];
    assign sr2 = sr2_s;

    // Operand forwarding; the execute-stage result is the youngest value and wins
    always_comb begin
        op_a_s = VSR1;
        op_b_s = VSR2;
        if (BYPASS_EN) begin
            if (bypass_alu_1) begin
                op_a_s = aluout_r;
            end else if (bypass_mem_1) begin
                op_a_s = Mem_Bypass_Val;
            end else begin
                op_a_s = VSR1;
            end
            if (bypass_alu_2) begin
                op_b_s = aluout_r;
            end else if (bypass_mem_2) begin
                op_b_s = Mem_Bypass_Val;
            end else begin
                op_b_s = VSR2;
            end
        end else begin
            op_a_s = VSR1;
            op_b_s = VSR2;
        end
    end

    assign imm5_s = {{11{IR[4]}}, IR[4:0]};

    // Second ALU operand: register B or the sign-extended 5-bit immediate
    always_comb begin
        if (op2select_s) begin
            op2_s = op_b_s;
        end else begin
            op2_s = imm5_s;
        end
    end

    // ALU; the adder wraps modulo 2^16 and the carry is discarded
    always_comb begin
        alu_result_s = 16'h0000;
        case (alu_control_s)
            ALU_ADD:  alu_result_s = op_a_s + op2_s;
            ALU_AND:  alu_result_s = op_a_s & op2_s;
            ALU_NOT:  alu_result_s = ~op_a_s;
            ALU_PASS: alu_result_s = op_a_s;
            default:  alu_result_s = 16'h0000;
        endcase
    end

    // Address offset selection from the instruction's offset fields
    always_comb begin
        offset_s = 16'h0000;
        case (pcselect1_s)
            2'b00:   offset_s = {{5{IR[10]}}, IR[10:0]};
            2'b01:   offset_s = {{7{IR[8]}},  IR[8:0]};
            2'b10:   offset_s = {{10{IR[5]}}, IR[5:0]};
            2'b11:   offset_s = 16'h0000;
            default: offset_s = 16'h0000;
        endcase
    end

    // Address base: PC-relative or register-relative
    always_comb begin
        if (pcselect2_s) begin
            base_s = npc_in;
        end else begin
            base_s = op_a_s;
        end
    end

    assign addr_s = base_s + offset_s;

    // Result-source and branch-mask decode from the opcode
    always_comb begin
        is_alu_op_s = 1'b0;
        nzp_next_s  = 3'b000;
        case (opcode_s)
            OP_ADD, OP_AND, OP_NOT: begin
                is_alu_op_s = 1'b1;
                nzp_next_s  = 3'b000;
            end
            OP_BR: begin
                is_alu_op_s = 1'b0;
                nzp_next_s  = IR[11:9];
            end
            OP_JMP: begin
                is_alu_op_s = 1'b0;
                nzp_next_s  = 3'b111;
            end
            default: begin
                is_alu_op_s = 1'b0;
                nzp_next_s  = 3'b000;
            end
        endcase
    end

    // Pipeline register; a stalled edge holds the results but drops the branch request
    always_ff @(posedge clock) begin
        if (!reset) begin
            aluout_r      <= 16'h0000;
            pcout_r       <= 16'h0000;
            w_control_r   <= 2'b00;
            mem_control_r <= 1'b0;
            m_data_r      <= 16'h0000;
            ir_exec_r     <= 16'h0000;
            nzp_r         <= 3'b000;
        end else if (enable_execute) begin
            aluout_r      <= is_alu_op_s ? alu_result_s : addr_s;
            pcout_r       <= addr_s;
            w_control_r   <= W_control_in;
            mem_control_r <= Mem_control_in;
            m_data_r      <= op_b_s;
            ir_exec_r     <= IR;
            nzp_r         <= nzp_next_s;
        end else begin
            nzp_r         <= 3'b000;
        end
    end

    assign aluout          = aluout_r;
    assign pcout           = pcout_r;
    assign W_control_out   = w_control_r;
    assign Mem_control_out = mem_control_r;
    assign M_data          = m_data_r;
    assign IR_Exec         = ir_exec_r;
    assign NZP             = nzp_r;

endmodule

// File: tb/tb_lc3_execute.sv
// Testbench for lc3_execute: directed scenarios with literal expectations,
// then randomized traffic, every cycle compared against a behavioural model.
module tb_lc3_execute;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable_execute;
    logic [15:0] IR;
    logic [15:0] npc_in;
    logic [5:0]  E_control;
    logic [1:0]  W_control_in;
    logic        Mem_control_in;
    logic [15:0] VSR1, VSR2;
    logic        bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;
    logic [15:0] Mem_Bypass_Val;
    logic [15:0] aluout, pcout, M_data, IR_Exec;
    logic [1:0]  W_control_out;
    logic        Mem_control_out;
    logic [2:0]  NZP, dr, sr1, sr2;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: what the registered outputs must hold
    logic [15:0] m_aluout, m_pcout, m_mdata, m_ir;
    logic [1:0]  m_w;
    logic        m_mem;
    logic [2:0]  m_nzp;

    lc3_execute #(.BYPASS_EN(1'b1)) dut (
        .clock(clock), .reset(reset), .enable_execute(enable_execute),
        .IR(IR), .npc_in(npc_in), .E_control(E_control),
        .W_control_in(W_control_in), .Mem_control_in(Mem_control_in),
        .VSR1(VSR1), .VSR2(VSR2),
        .bypass_alu_1(bypass_alu_1), .bypass_alu_2(bypass_alu_2),
        .bypass_mem_1(bypass_mem_1), .bypass_mem_2(bypass_mem_2),
        .Mem_Bypass_Val(Mem_Bypass_Val),
        .aluout(aluout), .pcout(pcout), .W_control_out(W_control_out),
        .Mem_control_out(Mem_control_out), .M_data(M_data), .IR_Exec(IR_Exec),
        .NZP(NZP), .dr(dr), .sr1(sr1), .sr2(sr2)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    // Sign-extend the low 'bits' bits of v as a plain integer, truncated to 16 bits
    function automatic logic [15:0] sx(input int v, input int bits);
        int x;
        x = v & ((1 << bits) - 1);
        if (x >= (1 << (bits - 1))) x = x - (1 << bits);
        return 16'(x);
    endfunction

    // Advance the model by one rising edge using the current inputs
    task automatic model_edge();
        logic [15:0] a, b, op2, alu, addr;
        int op, off;
        if (!reset) begin
            m_aluout = 16'h0; m_pcout = 16'h0; m_mdata = 16'h0; m_ir = 16'h0;
            m_w = 2'b00; m_mem = 1'b0; m_nzp = 3'b000;
        end else if (enable_execute) begin
            a = bypass_alu_1 ? m_aluout : (bypass_mem_1 ? Mem_Bypass_Val : VSR1);
            b = bypass_alu_2 ? m_aluout : (bypass_mem_2 ? Mem_Bypass_Val : VSR2);
            op2 = E_control[0] ? b : sx(int'(IR[4:0]), 5);
            case (E_control[5:4])
                2'd0:    alu = 16'((int'(a) + int'(op2)) % 65536);
                2'd1:    alu = a & op2;
                2'd2:    alu = 16'hFFFF - a;
                default: alu = a;
            endcase
            case (E_control[3:2])
                2'd0:    off = int'(sx(int'(IR[10:0]), 11));
                2'd1:    off = int'(sx(int'(IR[8:0]), 9));
                2'd2:    off = int'(sx(int'(IR[5:0]), 6));
                default: off = 0;
            endcase
            addr = 16'(((E_control[1] ? int'(npc_in) : int'(a)) + off) % 65536);
            op = int'(IR[15:12]);
            m_aluout = (op == 1 || op == 5 || op == 9) ? alu : addr;
            m_pcout  = addr;
            m_mdata  = b;
            m_ir     = IR;
            m_w      = W_control_in;
            m_mem    = Mem_control_in;
            m_nzp    = (op == 0) ? IR[11:9] : ((op == 12) ? 3'b111 : 3'b000);
        end else begin
            m_nzp = 3'b000;
        end
    endtask

    // Compare every output against the model (registered and decoded)
    task automatic check_all();
        int op;
        logic [2:0] e_sr2;
        op = int'(IR[15:12]);
        e_sr2 = (op == 3 || op == 7 || op == 11) ? IR[11:9] : IR[2:0];
        chk("aluout", aluout, m_aluout);
        chk("pcout", pcout, m_pcout);
        chk("M_data", M_data, m_mdata);
        chk("IR_Exec", IR_Exec, m_ir);
        chk("W_control_out", {14'h0, W_control_out}, {14'h0, m_w});
        chk("Mem_control_out", {15'h0, Mem_control_out}, {15'h0, m_mem});
        chk("NZP", {13'h0, NZP}, {13'h0, m_nzp});
        chk("dr", {13'h0, dr}, {13'h0, IR[11:9]});
        chk("sr1", {13'h0, sr1}, {13'h0, IR[8:6]});
        chk("sr2", {13'h0, sr2}, {13'h0, e_sr2});
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_all();
    endtask

    task automatic setin(input logic [15:0] ir, input logic [15:0] npc, input logic [5:0] ec,
                         input logic [15:0] v1, input logic [15:0] v2);
        IR = ir; npc_in = npc; E_control = ec; VSR1 = v1; VSR2 = v2;
        bypass_alu_1 = 1'b0; bypass_alu_2 = 1'b0; bypass_mem_1 = 1'b0; bypass_mem_2 = 1'b0;
        Mem_Bypass_Val = 16'h0000; W_control_in = 2'b00; Mem_control_in = 1'b0;
        enable_execute = 1'b1; reset = 1'b1;
    endtask

    initial begin
        setin(16'h0000, 16'h0000, 6'b000000, 16'h0000, 16'h0000);
        reset = 1'b0;
        @(negedge clock);
        tick();
        chk("reset_aluout", aluout, 16'h0000);
        chk("reset_nzp", {13'h0, NZP}, 16'h0000);

        // ADD immediate
        setin(16'h1262, 16'h0000, 6'b000000, 16'h0005, 16'h0000);
        W_control_in = 2'b10; Mem_control_in = 1'b1;
        tick();
        chk("add_imm", aluout, 16'h0007);
        chk("add_ir", IR_Exec, 16'h1262);
        chk("add_dr", {13'h0, dr}, 16'h0001);
        chk("add_wc", {14'h0, W_control_out}, 16'h0002);

        // ADD wrap then ALU bypass of the wrapped result
        setin(16'h1261, 16'h0000, 6'b000000, 16'hFFFF, 16'h0000);
        tick();
        chk("add_wrap", aluout, 16'h0000);
        bypass_alu_1 = 1'b1;
        tick();
        chk("alu_bypass", aluout, 16'h0001);

        // Branch target, then a stalled edge drops NZP but holds pcout
        setin(16'h0A05, 16'h3001, 6'b000110, 16'h0000, 16'h0000);
        tick();
        chk("br_pcout", pcout, 16'h3006);
        chk("br_nzp", {13'h0, NZP}, 16'h0005);
        enable_execute = 1'b0;
        tick();
        chk("stall_nzp", {13'h0, NZP}, 16'h0000);
        chk("stall_pcout", pcout, 16'h3006);

        // STR: address from base register, store data via sr2
        setin(16'h7A43, 16'h0000, 6'b001000, 16'h4000, 16'h1234);
        tick();
        chk("str_sr2", {13'h0, sr2}, 16'h0005);
        chk("str_pcout", pcout, 16'h4003);
        chk("str_aluout", aluout, 16'h4003);
        chk("str_mdata", M_data, 16'h1234);

        // Bypass priority on operand B
        setin(16'h1000, 16'h0000, 6'b110000, 16'h5555, 16'h0000);
        tick();
        chk("pass_a", aluout, 16'h5555);
        setin(16'h5001, 16'h0000, 6'b010001, 16'hFFFF, 16'h0000);
        bypass_alu_2 = 1'b1; bypass_mem_2 = 1'b1; Mem_Bypass_Val = 16'hAAAA;
        tick();
        chk("prio_mdata", M_data, 16'h5555);
        chk("prio_and", aluout, 16'h5555);

        // JMP raises all NZP bits
        setin(16'hC1C0, 16'h0000, 6'b001100, 16'h2222, 16'h0000);
        tick();
        chk("jmp_nzp", {13'h0, NZP}, 16'h0007);
        chk("jmp_pc", pcout, 16'h2222);

        // Reset mid-stream overrides enable, then normal operation resumes
        setin(16'h1262, 16'h0000, 6'b000000, 16'h0005, 16'h0000);
        reset = 1'b0;
        tick();
        chk("midrst_aluout", aluout, 16'h0000);
        chk("midrst_ir", IR_Exec, 16'h0000);
        reset = 1'b1;
        tick();
        chk("after_rst", aluout, 16'h0007);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            IR = 16'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                case ($urandom_range(0, 5))
                    0: IR[15:12] = 4'b0001;
                    1: IR[15:12] = 4'b0101;
                    2: IR[15:12] = 4'b1001;
                    3: IR[15:12] = 4'b0000;
                    4: IR[15:12] = 4'b1100;
                    default: IR[15:12] = 4'b0111;
                endcase
            end
            npc_in = 16'($urandom);
            E_control = 6'($urandom);
            W_control_in = 2'($urandom);
            Mem_control_in = 1'($urandom);
            VSR1 = 16'($urandom);
            VSR2 = 16'($urandom);
            bypass_alu_1 = 1'($urandom);
            bypass_alu_2 = 1'($urandom);
            bypass_mem_1 = 1'($urandom);
            bypass_mem_2 = 1'($urandom);
            Mem_Bypass_Val = 16'($urandom);
            enable_execute = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 31) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lc3_execute.md
Name: lc3_execute

Overview:
- Execute stage of the LC-3 pipeline, directly downstream of decode.
- Consumes the decode outputs (IR, npc, E_control, W_control, Mem_control) plus register-file read values.
- Performs ALU and address arithmetic, and resolves operand bypassing.
- Registers results for the writeback and memory-access stages; one-cycle latency.

Parameters:
BYPASS_EN, 1, 1 = bypass muxes active; 0 = bypass inputs ignored, operands always VSR1/VSR2

Ports:
clock  input  1  stage clock; all state on rising edge
reset  input  1  synchronous, active-low reset (0 = reset asserted), sampled on rising clock edge
enable_execute  input  1  stage advance; registers load only when 1
IR  input  16  instruction from decode
npc_in  input  16  PC+1 from decode
E_control  input  6  [5:4] alu_control, [3:2] pcselect1, [1] pcselect2, [0] op2select
W_control_in  input  2  writeback select from decode, passed through
Mem_control_in  input  1  memory control from decode, passed through
VSR1  input  16  register-file value of sr1
VSR2  input  16  register-file value of sr2
bypass_alu_1  input  1  operand A takes registered aluout
bypass_alu_2  input  1  operand B takes registered aluout
bypass_mem_1  input  1  operand A takes Mem_Bypass_Val
bypass_mem_2  input  1  operand B takes Mem_Bypass_Val
Mem_Bypass_Val  input  16  forwarded memory-stage data
aluout  output  16  registered ALU result or effective address
pcout  output  16  registered effective address / branch target
W_control_out  output  2  registered W_control_in
Mem_control_out  output  1  registered Mem_control_in
M_data  output  16  registered store data (operand B)
IR_Exec  output  16  registered IR
NZP  output  3  registered branch condition mask
dr  output  3  combinational IR[11:9]
sr1  output  3  combinational IR[8:6]
sr2  output  3  combinational; IR[11:9] if IR[15:12] is 0011, 0111 or 1011 (ST/STR/STI), else IR[2:0]

Behaviour:
- Reset (reset==0 at clock edge): aluout, pcout, M_data, IR_Exec = 16'h0000; W_control_out = 2'b00; Mem_control_out = 0; NZP = 3'b000. Reset overrides enable_execute and may occur mid-stream.
- Operand A = bypass_alu_1 ? aluout(current reg) : bypass_mem_1 ? Mem_Bypass_Val : VSR1. ALU bypass has priority when both bypass_alu_1 and bypass_mem_1 are set. Operand B uses the same rule with _2 and VSR2. BYPASS_EN=0 forces A=VSR1, B=VSR2.
- op2 = op2select ? B : sext16(IR[4:0]).
- ALU:
  - alu_control 00: A+op2, mod 2^16, no carry out.
  - alu_control 01: A & op2.
  - alu_control 10: ~A.
  - alu_control 11: A.
- Offset:
  - pcselect1 00: sext16(IR[10:0]).
  - pcselect1 01: sext16(IR[8:0]).
  - pcselect1 10: sext16(IR[5:0]).
  - pcselect1 11: 0.
- Base = pcselect2 ? npc_in : A. addr = base + offset, mod 2^16.
- On rising edge with reset==1 and enable_execute==1:
  - aluout <= ALU result if IR[15:12] ∈ {0001, 0101, 1001}, else addr.
  - pcout <= addr; M_data <= B; IR_Exec <= IR; W_control_out <= W_control_in; Mem_control_out <= Mem_control_in.
  - NZP <= IR[11:9] if IR[15:12]==0000 (BR); 3'b111 if 1100 (JMP/RET); else 000.
- enable_execute==0: all registered outputs hold, except NZP, which clears to 000 on that edge. A branch request therefore lasts at most one cycle per enabled instruction.
- Latency: inputs sampled at edge N appear on outputs after edge N; dr/sr1/sr2 have zero latency from IR.
- No internal stall or handshake state; back-pressure comes solely via enable_execute.

Test Plan:
- ADD imm: IR=16'h1262 (R1←R1+2), VSR1=16'h0005, E_control=6'b000000, enable=1 -> next cycle aluout=16'h0007, IR_Exec=16'h1262, NZP=000, dr=1, sr1=1.
- ADD wrap + ALU bypass: VSR1=16'hFFFF, IR=16'h1261, then next cycle bypass_alu_1=1 with the same IR -> aluout=16'h0000, then 16'h0001 (old aluout used, not VSR1).
- BR target: IR=16'h0A05 (BRnp +5), npc_in=16'h3001, E_control=6'b000110 -> pcout=16'h3006, NZP=3'b101; next cycle enable=0 -> NZP=000, pcout holds 16'h3006.
- STR: IR=16'h7A43, VSR2=16'h1234, VSR1=16'h4000, E_control=6'b001000 -> sr2=5, pcout=aluout=16'h4003, M_data=16'h1234.
- Bypass priority: bypass_alu_2=bypass_mem_2=1, Mem_Bypass_Val=16'hAAAA, aluout=16'h5555, op2select=1, AND -> operand B=16'h5555.
- Reset mid-stream: after a non-zero result, drive reset=0 with enable=1 for one edge -> all registered outputs 0; release reset -> the next enabled instruction computes normally.
